// File: rtl/fft_bfly_issue.sv
// Radix-2 DIT butterfly issue sequencer for a 256-point FFT.
// Walks 8 stages of 128 butterflies, gated between stages by writeback's stage_done.
module fft_bfly_issue #(
    parameter int DW = 20
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_stage_done,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_rd_en,
    output logic          o_rd_bank,
    output logic [7:0]    o_rd_addr_a,
    output logic [7:0]    o_rd_addr_b,
    output logic [6:0]    o_tw_addr,
    input  logic [DW-1:0] i_rd_a_re,
    input  logic [DW-1:0] i_rd_a_im,
    input  logic [DW-1:0] i_rd_b_re,
    input  logic [DW-1:0] i_rd_b_im,
    input  logic [DW-1:0] i_tw_re,
    input  logic [DW-1:0] i_tw_im,
    output logic          o_pushin,
    output logic [DW-1:0] o_x1real,
    output logic [DW-1:0] o_x1imag,
    output logic [DW-1:0] o_x2real,
    output logic [DW-1:0] o_x2imag,
    output logic [DW-1:0] o_wreal,
    output logic [DW-1:0] o_wimag,
    output logic [3:0]    o_level,
    output logic [17:0]   o_cntrl_in
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic [1:0]  r_state;
    logic [2:0]  r_s;
    logic [6:0]  r_j;
    logic        r_v1;
    logic [17:0] r_tag1;
    logic [3:0]  r_lvl1;

    logic        w_issue;
    logic [7:0]  w_j8;
    logic [7:0]  w_h;
    logic [7:0]  w_mask;
    logic [7:0]  w_a;
    logic [7:0]  w_b;
    logic [6:0]  w_p;
    logic [6:0]  w_k;
    logic [17:0] w_tag;

    // a inserts a zero at bit s of j (group bits move up one), b sets that bit
    assign w_issue = (r_state == S_ISSUE);
    assign w_j8    = {1'b0, r_j};
    assign w_h     = 8'd1 << r_s;
    assign w_mask  = w_h - 8'd1;
    assign w_a     = ((w_j8 & ~w_mask) << 1) | (w_j8 & w_mask);
    assign w_b     = w_a | w_h;
    assign w_p     = r_j & w_mask[6:0];
    assign w_k     = w_p << (3'd7 - r_s);
    assign w_tag   = {r_s, (r_j == 7'd127), ~r_s[0], w_a, 5'd0};

    assign o_rd_en     = w_issue;
    assign o_rd_bank   = w_issue & r_s[0];
    assign o_rd_addr_a = w_issue ? w_a : 8'd0;
    assign o_rd_addr_b = w_issue ? w_b : 8'd0;
    assign o_tw_addr   = w_issue ? w_k : 7'd0;
    assign o_busy      = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign o_done      = (r_state == S_FIN);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_s     <= 3'd0;
            r_j     <= 7'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_ISSUE;
                        r_s     <= 3'd0;
                        r_j     <= 7'd0;
                    end
                end
                S_ISSUE: begin
                    r_j <= r_j + 7'd1;
                    if (r_j == 7'd127) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_stage_done) begin
                        if (r_s == 3'd7) begin
                            r_state <= S_FIN;
                        end else begin
                            r_s     <= r_s + 3'd1;
                            r_j     <= 7'd0;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_s     <= 3'd0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Two-stage issue pipeline: tag waits one cycle for RAM/ROM data, then both register out
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_v1       <= 1'b0;
            r_tag1     <= 18'd0;
            r_lvl1     <= 4'd0;
            o_pushin   <= 1'b0;
            o_x1real   <= '0;
            o_x1imag   <= '0;
            o_x2real   <= '0;
            o_x2imag   <= '0;
            o_wreal    <= '0;
            o_wimag    <= '0;
            o_level    <= 4'd0;
            o_cntrl_in <= 18'd0;
        end else begin
            r_v1     <= w_issue;
            o_pushin <= r_v1;
            if (w_issue) begin
                r_tag1 <= w_tag;
                r_lvl1 <= {1'b0, r_s};
            end
            if (r_v1) begin
                o_x1real   <= i_rd_a_re;
                o_x1imag   <= i_rd_a_im;
                o_x2real   <= i_rd_b_re;
                o_x2imag   <= i_rd_b_im;
                o_wreal    <= i_tw_re;
                o_wimag    <= i_tw_im;
                o_level    <= r_lvl1;
                o_cntrl_in <= r_tag1;
            end
        end
    end

endmodule

// File: tb/tb_fft_bfly_issue.sv
// Randomized bench for fft_bfly_issue against a butterfly-index reference model.
module tb_fft_bfly_issue;
    localparam int DW = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          sd = 1'b0;
    logic [DW-1:0] d_a_re = '0, d_a_im = '0, d_b_re = '0, d_b_im = '0, d_tw_re = '0, d_tw_im = '0;

    logic          w_busy, w_done, w_rd_en, w_rd_bank, w_pushin;
    logic [7:0]    w_rd_addr_a, w_rd_addr_b;
    logic [6:0]    w_tw_addr;
    logic [DW-1:0] w_x1real, w_x1imag, w_x2real, w_x2imag, w_wreal, w_wimag;
    logic [3:0]    w_level;
    logic [17:0]   w_cntrl_in;

    fft_bfly_issue #(.DW(DW)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_stage_done(sd),
        .o_busy(w_busy), .o_done(w_done), .o_rd_en(w_rd_en), .o_rd_bank(w_rd_bank),
        .o_rd_addr_a(w_rd_addr_a), .o_rd_addr_b(w_rd_addr_b), .o_tw_addr(w_tw_addr),
        .i_rd_a_re(d_a_re), .i_rd_a_im(d_a_im), .i_rd_b_re(d_b_re), .i_rd_b_im(d_b_im),
        .i_tw_re(d_tw_re), .i_tw_im(d_tw_im),
        .o_pushin(w_pushin), .o_x1real(w_x1real), .o_x1imag(w_x1imag),
        .o_x2real(w_x2real), .o_x2imag(w_x2imag), .o_wreal(w_wreal), .o_wimag(w_wimag),
        .o_level(w_level), .o_cntrl_in(w_cntrl_in)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model: n counts butterflies issued in the transform (0..1023)
    bit m_issuing, m_waiting, m_fin;
    int m_n;
    bit p1_valid;
    int p1_n;
    bit e_push;
    int e_n;
    logic [DW-1:0] e_x1r, e_x1i, e_x2r, e_x2i, e_wr, e_wi;
    logic [3:0]    e_level;
    logic [17:0]   e_cntrl;

    bit auto_sd = 0;
    bit fixed_data = 0;
    int sd_cd = 0;
    int push_cnt = 0, done_cnt = 0, sd_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic exp_addr(input int n, output int s, output int j, output int a,
                            output int b, output int k);
        int h, g, p;
        s = n / 128;
        j = n % 128;
        h = 1 << s;
        g = j / h;
        p = j % h;
        a = g * 2 * h + p;
        b = a + h;
        k = p * (128 / h);
    endtask

    task automatic model_reset();
        m_issuing = 0; m_waiting = 0; m_fin = 0; m_n = 0;
        p1_valid = 0; p1_n = 0; e_push = 0; e_n = 0;
        e_x1r = '0; e_x1i = '0; e_x2r = '0; e_x2i = '0; e_wr = '0; e_wi = '0;
        e_level = '0; e_cntrl = '0;
    endtask

    task automatic model_step();
        int s, j, a, b, k;
        if (reset) begin
            model_reset();
            return;
        end
        if (p1_valid) begin
            exp_addr(p1_n, s, j, a, b, k);
            e_push  = 1;
            e_n     = p1_n;
            e_level = 4'(s);
            e_cntrl = 18'((s << 15) | ((j == 127 ? 1 : 0) << 14) | ((1 - s % 2) << 13) | (a << 5));
            e_x1r = d_a_re; e_x1i = d_a_im; e_x2r = d_b_re; e_x2i = d_b_im;
            e_wr = d_tw_re; e_wi = d_tw_im;
        end else begin
            e_push = 0;
        end
        p1_valid = m_issuing;
        p1_n     = m_n;
        if (m_fin) begin
            m_fin = 0;
        end else if (m_issuing) begin
            m_n++;
            if (m_n % 128 == 0) begin
                m_issuing = 0;
                m_waiting = 1;
            end
        end else if (m_waiting) begin
            if (sd) begin
                m_waiting = 0;
                if (m_n == 1024) m_fin = 1;
                else m_issuing = 1;
            end
        end else if (start) begin
            m_issuing = 1;
            m_n = 0;
        end
    endtask

    task automatic compare();
        int s, j, a, b, k;
        chk("rd_en", w_rd_en, m_issuing);
        chk("busy", w_busy, m_issuing | m_waiting);
        chk("done", w_done, m_fin);
        if (m_issuing) begin
            exp_addr(m_n, s, j, a, b, k);
            chk("addr_a", w_rd_addr_a, a);
            chk("addr_b", w_rd_addr_b, b);
            chk("tw_addr", w_tw_addr, k);
            chk("rd_bank", w_rd_bank, s % 2);
            if (m_n == 0) begin
                chk("s0j0_a", w_rd_addr_a, 0); chk("s0j0_b", w_rd_addr_b, 1);
                chk("s0j0_k", w_tw_addr, 0);   chk("s0j0_bank", w_rd_bank, 0);
            end
            if (m_n == 1) begin
                chk("s0j1_a", w_rd_addr_a, 2); chk("s0j1_b", w_rd_addr_b, 3);
            end
            if (m_n == 128) begin
                chk("s1j0_a", w_rd_addr_a, 0); chk("s1j0_b", w_rd_addr_b, 2);
            end
            if (m_n == 3 * 128 + 9) begin
                chk("s3j9_a", w_rd_addr_a, 17); chk("s3j9_b", w_rd_addr_b, 25);
                chk("s3j9_k", w_tw_addr, 16);   chk("s3j9_bank", w_rd_bank, 1);
            end
            if (m_n == 7 * 128 + 5) begin
                chk("s7j5_a", w_rd_addr_a, 5); chk("s7j5_b", w_rd_addr_b, 133);
                chk("s7j5_k", w_tw_addr, 5);   chk("s7j5_bank", w_rd_bank, 1);
            end
        end
        chk("pushin", w_pushin, e_push);
        chk("x1real", w_x1real, e_x1r);
        chk("x1imag", w_x1imag, e_x1i);
        chk("x2real", w_x2real, e_x2r);
        chk("x2imag", w_x2imag, e_x2i);
        chk("wreal", w_wreal, e_wr);
        chk("wimag", w_wimag, e_wi);
        chk("level", w_level, e_level);
        chk("cntrl_in", w_cntrl_in, e_cntrl);
        if (e_push && e_n == 0) chk("s0j0_cntrl", w_cntrl_in, 18'h02000);
        if (e_push && e_n == 3 * 128 + 9) chk("s3j9_level", w_level, 3);
        if (w_pushin) push_cnt++;
        if (w_done) done_cnt++;
    endtask

    task automatic drive_next();
        start = 0;
        sd = 0;
        if (auto_sd && w_pushin && w_cntrl_in[14]) begin
            sd_cd = 6;
        end else if (sd_cd > 0) begin
            sd_cd--;
            if (sd_cd == 0) begin
                sd = 1;
                sd_cnt++;
            end
        end
        if (!fixed_data) begin
            d_a_re = DW'($urandom); d_a_im = DW'($urandom); d_b_re = DW'($urandom);
            d_b_im = DW'($urandom); d_tw_re = DW'($urandom); d_tw_im = DW'($urandom);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        compare();
        drive_next();
    endtask

    task automatic fail_timeout(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL timeout %s: got no event, required within budget (cycle %0d)", nm, cyc);
    endtask

    task automatic wait_issue(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            tick();
            if (m_issuing && m_n == target) break;
        end
        if (i == budget) fail_timeout($sformatf("issue_%0d", target));
    endtask

    task automatic async_reset_check();
        reset = 1;
        #1;
        chk("rst_pushin", w_pushin, 0);   chk("rst_rd_en", w_rd_en, 0);
        chk("rst_busy", w_busy, 0);       chk("rst_done", w_done, 0);
        chk("rst_addr_a", w_rd_addr_a, 0); chk("rst_addr_b", w_rd_addr_b, 0);
        chk("rst_tw", w_tw_addr, 0);      chk("rst_bank", w_rd_bank, 0);
        chk("rst_x1real", w_x1real, 0);   chk("rst_wimag", w_wimag, 0);
        chk("rst_level", w_level, 0);     chk("rst_cntrl", w_cntrl_in, 0);
        model_reset();
        sd_cd = 0;
        auto_sd = 0;
        repeat (3) tick();
        reset = 0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        async_reset_check();
        repeat (5) tick();

        // Stage gating: no stage_done response, stray pulses during ISSUE
        start = 1;
        wait_issue(50, 100);
        sd = 1;
        wait_issue(127, 200);
        sd = 1;
        repeat (40) tick();
        sd = 1;
        wait_issue(128, 5);
        auto_sd = 1;
        wait_issue(3 * 128 + 20, 1500);
        async_reset_check();

        // Idle after reset, then a complete transform with a stray start mid-run
        repeat (10) tick();
        push_cnt = 0; done_cnt = 0; sd_cnt = 0;
        auto_sd = 1;
        start = 1;
        wait_issue(500, 1500);
        start = 1;
        begin
            int i;
            for (i = 0; i < 3000; i++) begin
                tick();
                if (m_fin) break;
            end
            if (i == 3000) fail_timeout("done");
        end
        repeat (12) tick();
        chk("push_total", push_cnt, 1024);
        chk("done_total", done_cnt, 1);
        chk("stage_done_total", sd_cnt, 8);

        // Fixed operand data: pass-through and hold while pushin is low
        auto_sd = 0;
        fixed_data = 1;
        d_a_re = 20'h12345; d_a_im = 20'h0; d_b_re = 20'h0;
        d_b_im = 20'hFFFFE; d_tw_re = 20'h7FFFF; d_tw_im = 20'h0;
        start = 1;
        wait_issue(127, 200);
        repeat (8) tick();
        chk("hold_pushin", w_pushin, 0);
        chk("hold_x1real", w_x1real, 20'h12345);
        chk("hold_x2imag", w_x2imag, 20'hFFFFE);
        chk("hold_wreal", w_wreal, 20'h7FFFF);
        async_reset_check();
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 2 ms");
        $fatal(1);
    end
endmodule
